// File: rtl/spi_slave_shifter_pkg.sv
// Shared SPI-path definitions.
// Holds the FSM encoding and default byte width.
package spi_slave_shifter_pkg;

  localparam int SPI_DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line.
// Exposes the last two stages so the parent can detect edges.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_d
);

  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stg <= {stg[SYNC_STAGES-2:0], d};
    end
  end

  assign q   = stg[SYNC_STAGES-2];
  assign q_d = stg[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave byte shifter.
// Receives on mosi, transmits data_in on miso, one byte per LOAD.
module spi_slave_shifter
  import spi_slave_shifter_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = SPI_DATA_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      cs,
  input  logic                      mosi,
  output logic                      miso,
  input  logic [SPI_DATA_WIDTH-1:0] data_in,
  output logic                      ready,
  output logic                      flag_start,
  output logic [SPI_DATA_WIDTH-1:0] data_out,
  output logic                      rx_valid
);

  localparam int CW = $clog2(SPI_DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(SPI_DATA_WIDTH - 1);

  logic sclk_q, sclk_qd;
  logic cs_q, cs_qd;
  logic mosi_q, mosi_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .d   (sclk),
    .q   (sclk_q),
    .q_d (sclk_qd)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d   (cs),
    .q   (cs_q),
    .q_d (cs_qd)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d   (mosi),
    .q   (mosi_q),
    .q_d (mosi_unused)
  );

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_rise = sclk_q & ~sclk_qd;
  assign sclk_fall = ~sclk_q & sclk_qd;
  assign cs_rise   = cs_q & ~cs_qd;
  assign cs_fall   = ~cs_q & cs_qd;

  spi_state_t                state;
  logic [SPI_DATA_WIDTH-1:0] tx;
  logic [SPI_DATA_WIDTH-1:0] rx;
  logic [SPI_DATA_WIDTH-1:0] rx_next;
  logic [CW-1:0]             cnt;

  assign rx_next = {rx[SPI_DATA_WIDTH-2:0], mosi_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      cnt        <= '0;
      miso       <= 1'b0;
      ready      <= 1'b1;
      flag_start <= 1'b0;
      rx_valid   <= 1'b0;
      data_out   <= '0;
    end else begin
      flag_start <= 1'b0;
      rx_valid   <= 1'b0;
      unique case (state)
        IDLE: begin
          ready <= 1'b1;
          miso  <= 1'b0;
          if (cs_fall) begin
            flag_start <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (cs_rise) begin
            ready <= 1'b1;
            miso  <= 1'b0;
            state <= IDLE;
          end else begin
            tx    <= data_in;
            miso  <= data_in[SPI_DATA_WIDTH-1];
            cnt   <= LAST;
            ready <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // cs rise wins over any sclk edge seen in the same clk
          if (cs_rise) begin
            ready <= 1'b1;
            miso  <= 1'b0;
            state <= IDLE;
          end else if (sclk_rise) begin
            rx <= rx_next;
            if (cnt == '0) begin
              data_out <= rx_next;
              rx_valid <= 1'b1;
              ready    <= 1'b1;
              state    <= GAP;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else if (sclk_fall) begin
            tx   <= {tx[SPI_DATA_WIDTH-2:0], 1'b0};
            miso <= tx[SPI_DATA_WIDTH-2];
          end
        end
        GAP: begin
          if (cs_q) begin
            miso  <= 1'b0;
            state <= IDLE;
          end else if (sclk_fall) begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Randomized self-checking bench for spi_slave_shifter.
// Byte-level master model; a per-cycle process checks data_out/rx_valid.
module tb_spi_slave_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] data_in = 8'h00;
  logic       ready;
  logic       flag_start;
  logic [7:0] data_out;
  logic       rx_valid;

  spi_slave_shifter #(.SPI_DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso),
    .data_in    (data_in),
    .ready      (ready),
    .flag_start (flag_start),
    .data_out   (data_out),
    .rx_valid   (rx_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int falls = 0;
  int starts = 0;
  logic ready_prev = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic [7:0] tx_b[8];
  logic [7:0] rx_b[8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready_prev === 1'b1 && ready === 1'b0) falls++;
    ready_prev = ready;
    if (flag_start === 1'b1) starts++;
  end

  // received-byte scoreboard, checked every clk
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rx_valid_spurious", 1, 0);
        end else begin
          last_data = exp_q.pop_front();
          chk("data_out", data_out, last_data);
        end
      end else begin
        chk("data_out_hold", data_out, last_data);
      end
    end
  end

  // n bytes in one cs frame; cut<8 raises cs after cut pulses of the last byte
  task automatic burst(input int n, input int cut, input int half);
    logic [7:0] got;
    int f0, s0;
    f0 = falls;
    s0 = starts;
    for (int b = 0; b < n; b++)
      if (b < n - 1 || cut == 8) exp_q.push_back(rx_b[b]);
    data_in = tx_b[0];
    mosi = rx_b[0][7];
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < n; b++) begin
      got = '0;
      for (int i = 0; i < 8; i++) begin
        sclk = 1'b1;
        repeat (half) @(negedge clk);
        if (i == 1) data_in = 8'($urandom);
        if (i == 7 && b < n - 1) data_in = tx_b[b+1];
        got[7-i] = miso;
        if (b == n - 1 && i == cut - 1) begin
          sclk = 1'b0;
          cs = 1'b1;
          mosi = 1'b0;
          break;
        end
        sclk = 1'b0;
        if (i < 7) mosi = rx_b[b][6-i];
        else if (b < n - 1) mosi = rx_b[b+1][7];
        repeat (half) @(negedge clk);
      end
      if (b < n - 1 || cut == 8) chk("miso_byte", got, tx_b[b]);
    end
    repeat (8) @(negedge clk);
    chk("ready_falls", falls - f0, n);
    chk("flag_start_cnt", starts - s0, 1);
    chk("ready_idle", ready, 1);
    chk("miso_idle", miso, 0);
    chk("rx_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_outputs", {miso, ready, flag_start, rx_valid, data_out},
        {4'b0100, 8'h00});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    tx_b[0] = 8'h3C; rx_b[0] = 8'hA5;
    burst(1, 8, 2);
    chk("single_data_out", data_out, 8'hA5);

    tx_b[0] = 8'h12; rx_b[0] = 8'h5E;
    tx_b[1] = 8'h34; rx_b[1] = 8'hC3;
    burst(2, 8, 3);
    chk("b2b_data_out", data_out, 8'hC3);

    tx_b[0] = 8'h77; rx_b[0] = 8'h0F;
    burst(1, 5, 2);
    chk("abort_keep", data_out, 8'hC3);
    tx_b[0] = 8'h81; rx_b[0] = 8'h6D;
    burst(1, 8, 2);
    chk("after_abort", data_out, 8'h6D);

    data_in = 8'h5A; mosi = 1'b1; cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1; repeat (2) @(negedge clk);
      sclk = 1'b0; repeat (2) @(negedge clk);
    end
    sclk = 1'b1;
    @(negedge clk);
    #3 rst = 1'b0;
    last_data = 8'h00;
    #1;
    chk("rst_mid_byte", {miso, ready, flag_start, rx_valid, data_out},
        {4'b0100, 8'h00});
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tx_b[0] = 8'hFF; rx_b[0] = 8'h99;
    burst(1, 8, 2);

    begin
      int f0, s0;
      f0 = falls; s0 = starts;
      for (int i = 0; i < 10; i++) begin
        sclk = ~sclk;
        repeat (2) @(negedge clk);
        chk("cs_high_sclk", {ready, miso}, 2'b10);
      end
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      chk("cs_high_falls", falls - f0, 0);
      chk("cs_high_starts", starts - s0, 0);
    end

    for (int b = 0; b < 4; b++) begin
      tx_b[b] = 8'($urandom);
      rx_b[b] = 8'($urandom);
    end
    burst(4, 8, 2);

    for (int r = 0; r < 10; r++) begin
      int n, cut, half;
      n = $urandom_range(1, 4);
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      half = $urandom_range(2, 4);
      for (int b = 0; b < n; b++) begin
        tx_b[b] = 8'($urandom);
        rx_b[b] = 8'($urandom);
      end
      burst(n, cut, half);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
